// File: rtl/p4_ipv4_checksum_engine.sv
// p4_ipv4_checksum_engine
//   Shared IPv4 header checksum engine for NUM_CHANNELS user-extern channels.
//   Each channel queues requests in a small FIFO. A round-robin arbiter feeds
//   one header per cycle into a 3-stage one's-complement adder pipeline.
//   Generate channels return the checksum; verify channels return {15'b0, ok}.
// Ports:
//   clk            - single clock for all logic
//   aresetn        - asynchronous active-low reset
//   req_data       - 160-bit header per channel, byte 0 in the slice MSBs
//   req_valid      - one-cycle request strobe per channel (no backpressure)
//   resp_data      - 16-bit result per channel, held between responses
//   resp_valid     - one-cycle response strobe per channel
//   clear_overflow - clears the sticky overflow flags (a same-cycle drop wins)
//   overflow       - sticky per-channel "request dropped" flag
//   drop_count     - saturating total of dropped requests
module p4_ipv4_checksum_engine #(
    parameter int unsigned               NUM_CHANNELS = 2,
    parameter logic [NUM_CHANNELS-1:0]   CHANNEL_MODE = 2'b10,
    parameter int unsigned               FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [NUM_CHANNELS*160-1:0]  req_data,
    input  logic [NUM_CHANNELS-1:0]      req_valid,
    output logic [NUM_CHANNELS*16-1:0]   resp_data,
    output logic [NUM_CHANNELS-1:0]      resp_valid,
    input  logic                         clear_overflow,
    output logic [NUM_CHANNELS-1:0]      overflow,
    output logic [15:0]                  drop_count
);

    localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

    // Request FIFOs
    logic [159:0]            fifo_mem [NUM_CHANNELS][FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr   [NUM_CHANNELS];
    logic [AW-1:0]           rd_ptr   [NUM_CHANNELS];
    logic [AW:0]             fill     [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] empty, full, pop, accept, drop;

    // Arbiter
    logic [CW-1:0] last_grant, grant_ch, cand;
    logic          grant_valid;

    // Pipeline
    logic [159:0]  hdr;
    logic [18:0]   part_a, part_b;
    logic          s1_valid, s1_mode, s2_valid, s2_mode;
    logic [CW-1:0] s1_ch, s2_ch;
    logic [18:0]   s1_a, s1_b;
    logic [19:0]   sum20;
    logic [16:0]   fold1, s2_sum;
    logic [15:0]   fold2, result;

    // Drop accounting
    logic [3:0]    n_drop;
    logic [16:0]   dc_sum;

    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            empty[ch] = (fill[ch] == '0);
            full[ch]  = (fill[ch] == (AW+1)'(FIFO_DEPTH));
        end
    end

    // Round-robin: first non-empty channel after last_grant wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
            cand = CW'((32'(last_grant) + i) % NUM_CHANNELS);
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a write to a full FIFO that is
    // being popped is still accepted.
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            pop[ch]    = grant_valid && (grant_ch == CW'(ch));
            accept[ch] = req_valid[ch] && (!full[ch] || pop[ch]);
            drop[ch]   = req_valid[ch] && full[ch] && !pop[ch];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                wr_ptr[ch] <= '0;
                rd_ptr[ch] <= '0;
                fill[ch]   <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (accept[ch]) wr_ptr[ch] <= wr_ptr[ch] + 1'b1;
                if (pop[ch])    rd_ptr[ch] <= rd_ptr[ch] + 1'b1;
                case ({accept[ch], pop[ch]})
                    2'b10:   fill[ch] <= fill[ch] + 1'b1;
                    2'b01:   fill[ch] <= fill[ch] - 1'b1;
                    default: fill[ch] <= fill[ch];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (accept[ch]) fifo_mem[ch][wr_ptr[ch]] <= req_data[ch*160 +: 160];
        end
    end

    // Stage 1 input: head of the granted FIFO; generate mode zeroes bytes 10-11.
    always_comb begin
        hdr = fifo_mem[grant_ch][rd_ptr[grant_ch]];
        if (CHANNEL_MODE[grant_ch]) hdr[79:64] = '0;
        part_a = '0;
        part_b = '0;
        for (int unsigned w = 0; w < 5; w++) begin
            part_a = part_a + 19'(hdr[159 - 16*w -: 16]);
            part_b = part_b + 19'(hdr[79 - 16*w -: 16]);
        end
    end

    always_comb begin
        sum20  = 20'(s1_a) + 20'(s1_b);
        fold1  = 17'(sum20[15:0]) + 17'(sum20[19:16]);
        fold2  = s2_sum[15:0] + 16'(s2_sum[16]);
        result = s2_mode ? ~fold2 : {15'b0, (fold2 == 16'hFFFF)};
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant <= LAST_CH;
            s1_valid   <= 1'b0;
            s1_ch      <= '0;
            s1_mode    <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s2_valid   <= 1'b0;
            s2_ch      <= '0;
            s2_mode    <= 1'b0;
            s2_sum     <= '0;
        end else begin
            if (grant_valid) last_grant <= grant_ch;
            s1_valid <= grant_valid;
            s1_ch    <= grant_ch;
            s1_mode  <= CHANNEL_MODE[grant_ch];
            s1_a     <= part_a;
            s1_b     <= part_b;
            s2_valid <= s1_valid;
            s2_ch    <= s1_ch;
            s2_mode  <= s1_mode;
            s2_sum   <= fold1;
        end
    end

    // Stage 3 fold feeds the output registers directly.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                resp_valid[ch] <= s2_valid && (s2_ch == CW'(ch));
                if (s2_valid && (s2_ch == CW'(ch))) resp_data[ch*16 +: 16] <= result;
            end
        end
    end

    always_comb begin
        n_drop = '0;
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            n_drop = n_drop + 4'(drop[ch]);
        end
        dc_sum = 17'(drop_count) + 17'(n_drop);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow   <= '0;
            drop_count <= '0;
        end else begin
            overflow   <= (overflow & ~{NUM_CHANNELS{clear_overflow}}) | drop;
            drop_count <= dc_sum[16] ? 16'hFFFF : dc_sum[15:0];
        end
    end

endmodule

// File: tb/tb_p4_ipv4_checksum_engine.sv
// tb_p4_ipv4_checksum_engine
//   Directed bench for p4_ipv4_checksum_engine (2 channels: ch0 verify,
//   ch1 generate, FIFO depth 4). Expected responses are queued per channel
//   when a request is accepted and compared when resp_valid fires.
module tb_p4_ipv4_checksum_engine;

    localparam int unsigned N     = 2;
    localparam int unsigned DEPTH = 4;
    localparam logic [1:0]  MODE  = 2'b10;

    logic           clk = 1'b0;
    logic           aresetn = 1'b1;
    logic [N*160-1:0] req_data = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N*16-1:0] resp_data;
    logic [N-1:0]   resp_valid;
    logic           clear_overflow = 1'b0;
    logic [N-1:0]   overflow;
    logic [15:0]    drop_count;

    p4_ipv4_checksum_engine #(
        .NUM_CHANNELS (N),
        .CHANNEL_MODE (MODE),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .resp_data      (resp_data),
        .resp_valid     (resp_valid),
        .clear_overflow (clear_overflow),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard and reference state
    logic [15:0] sb0[$];
    logic [15:0] sb1[$];
    int          order_log[$];
    logic [15:0] last_data [2];
    int          resp_cyc  [2];
    int          m_cnt     [2];
    int          m_last;
    logic [1:0]  m_ovf;
    int          m_drop;
    int          req_cyc;

    function automatic logic [15:0] exp_resp(input int ch, input logic [159:0] h);
        logic [31:0]  s;
        logic [159:0] x;
        s = 32'd0;
        x = h;
        if (MODE[ch]) x[79:64] = 16'h0;
        for (int k = 0; k < 10; k++) s = s + 32'(x[159 - 16*k -: 16]);
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        if (MODE[ch]) return ~s[15:0];
        return (s[15:0] == 16'hFFFF) ? 16'h0001 : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (aresetn) begin
            for (int ch = 0; ch < N; ch++) begin
                if (resp_valid[ch]) begin
                    logic [15:0] got;
                    logic [15:0] want;
                    int          depth;
                    got   = resp_data[ch*16 +: 16];
                    depth = (ch == 0) ? sb0.size() : sb1.size();
                    n_vec++;
                    assert (depth != 0) else begin
                        n_err++;
                        $error("FAIL unexpected_resp ch%0d: observed resp_valid=1 data=%0h, expected no pending response", ch, got);
                    end
                    if (depth != 0) begin
                        if (ch == 0) want = sb0.pop_front();
                        else         want = sb1.pop_front();
                        n_vec++;
                        assert (got === want) else begin
                            n_err++;
                            $error("FAIL resp_data ch%0d: observed %0h expected %0h", ch, got, want);
                        end
                    end
                    last_data[ch] = got;
                    resp_cyc[ch]  = cyc;
                    order_log.push_back(ch);
                end
            end
        end
    end

    // One stimulus cycle; advances the reference FIFO/arbiter model in step.
    task automatic cycle(input logic [1:0] v, input logic [159:0] h0,
                         input logic [159:0] h1, input logic clr);
        int         g;
        logic [1:0] dropped;
        @(negedge clk);
        req_valid      = v;
        req_data       = {h1, h0};
        clear_overflow = clr;
        req_cyc        = cyc;
        g = -1;
        for (int i = 1; i <= N; i++) begin
            if (g < 0 && m_cnt[(m_last + i) % N] > 0) g = (m_last + i) % N;
        end
        if (g >= 0) begin
            m_cnt[g]--;
            m_last = g;
        end
        dropped = 2'b00;
        for (int ch = 0; ch < N; ch++) begin
            if (v[ch]) begin
                if (m_cnt[ch] < DEPTH) begin
                    m_cnt[ch]++;
                    if (ch == 0) sb0.push_back(exp_resp(0, h0));
                    else         sb1.push_back(exp_resp(1, h1));
                end else begin
                    dropped[ch] = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
        m_ovf = clr ? dropped : (m_ovf | dropped);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(2'b00, '0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sb0.size() + sb1.size()) != 0; i++) idle(1);
        idle(2);
        check("drain_pending", sb0.size() + sb1.size(), 0);
    endtask

    task automatic rst();
        @(negedge clk);
        #2;
        aresetn        = 1'b0;
        req_valid      = '0;
        clear_overflow = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        sb0.delete();
        sb1.delete();
        order_log.delete();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_last   = N - 1;
        m_ovf    = 2'b00;
        m_drop   = 0;
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [159:0] h_base, h_ok, h_bad, h0, h1;
        int t0;
        resp_cyc[0] = -1;
        resp_cyc[1] = -1;
        last_data[0] = '0;
        last_data[1] = '0;
        h_base = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;
        h_ok   = h_base;
        h_ok[79:64] = 16'hB861;
        h_bad  = h_base;
        h_bad[79:64] = 16'hB862;

        rst();

        // Generate on ch1: latency 4, checksum B861
        cycle(2'b10, '0, h_base, 1'b0);
        t0 = req_cyc;
        idle(6);
        check("gen_latency", resp_cyc[1], t0 + 4);
        check("gen_csum", last_data[1], 16'hB861);
        check("gen_ch0_hold", resp_data[15:0], 16'h0000);

        // Verify on ch0: good and bad checksum
        cycle(2'b01, h_ok, '0, 1'b0);
        t0 = req_cyc;
        idle(6);
        check("ver_latency", resp_cyc[0], t0 + 4);
        check("ver_ok", last_data[0], 16'h0001);
        check("ver_ch1_hold", resp_data[31:16], 16'hB861);
        cycle(2'b01, h_bad, '0, 1'b0);
        idle(6);
        check("ver_bad", last_data[0], 16'h0000);

        // Contention burst: both channels every cycle
        rst();
        for (int i = 0; i < 10; i++) begin
            h0 = {$urandom, $urandom, $urandom, $urandom, $urandom};
            h1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if (i % 2 == 0) begin
                h0[79:64] = 16'h0;
                h0[79:64] = exp_resp(1, h0);
            end
            cycle(2'b11, h0, h1, 1'b0);
        end
        drain();
        for (int i = 0; i < 8; i++) check($sformatf("order_%0d", i), order_log[i], i % 2);
        check("burst_overflow", 32'(overflow), 32'(m_ovf));
        check("burst_drop_count", 32'(drop_count), m_drop);
        check("burst_drop_count_abs", 32'(drop_count), 3);
        check("burst_overflow_abs", 32'(overflow), 2'b11);

        // Overflow clear coinciding with a drop, then a plain clear
        rst();
        for (int i = 0; i < 8; i++) cycle(2'b11, h_ok, h_base, 1'b1);
        idle(1);
        check("ovf_set_wins", 32'(overflow), 2'b10);
        check("ovf_set_wins_model", 32'(overflow), 32'(m_ovf));
        check("ovf_drop_count", 32'(drop_count), 1);
        cycle(2'b00, '0, '0, 1'b1);
        idle(1);
        check("ovf_cleared", 32'(overflow), 0);
        check("ovf_clear_keeps_count", 32'(drop_count), 1);
        drain();

        // Saturation of drop_count
        for (int i = 0; i < 65560; i++) cycle(2'b11, '0, '0, 1'b0);
        drain();
        check("drop_sat", 32'(drop_count), 16'hFFFF);
        check("drop_sat_model", 32'(drop_count), m_drop);

        // Reset with requests queued and in flight
        cycle(2'b11, h_ok, h_base, 1'b0);
        cycle(2'b11, h_ok, h_base, 1'b0);
        cycle(2'b11, h_ok, h_base, 1'b0);
        rst();
        idle(8);
        check("no_resp_after_reset", order_log.size(), 0);
        cycle(2'b11, h_ok, h_base, 1'b0);
        t0 = req_cyc;
        idle(7);
        check("post_rst_ch0_first", resp_cyc[0], t0 + 4);
        check("post_rst_ch1_second", resp_cyc[1], t0 + 5);
        check("post_rst_ch0_data", last_data[0], 16'h0001);
        check("post_rst_ch1_data", last_data[1], 16'hB861);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/p4_ipv4_checksum_engine.md
# p4_ipv4_checksum_engine

Shared, pipelined IPv4 header checksum engine serving NUM_CHANNELS VNP4 user-extern channels. Each channel is configured at elaboration for verify or generate mode. It replaces the per-extern verify and generate instances in the P4 router VNP4 wrapper. The user-extern interface cannot backpressure, so each channel has its own small request FIFO. A round-robin arbiter feeds one header per cycle into a single 3-stage one's-complement adder pipeline, and responses are returned in order on each channel.

## Interface
- NUM_CHANNELS, 2, number of user-extern channels (1..8)
- CHANNEL_MODE, 2'b10, per-channel mode bit: 0 = verify, 1 = generate (bit i is channel i)
- FIFO_DEPTH, 4, request FIFO depth per channel (power of 2, ≥2)
- clk  in  1  single clock for all logic; the VNP4 s_axis_aclk domain
- aresetn  in  1  reset, asynchronous assert, active-low
- req_data  in  NUM_CHANNELS*160  20-byte IPv4 header per channel; byte 0 in bits [159:152] of the channel slice
- req_valid  in  NUM_CHANNELS  single-cycle request strobe per channel; no ready
- resp_data  out  NUM_CHANNELS*16  generate: checksum; verify: {15'b0, ok}
- resp_valid  out  NUM_CHANNELS  single-cycle response strobe per channel
- clear_overflow  in  1  pulse that clears overflow flags
- overflow  out  NUM_CHANNELS  sticky flag per channel: a request was dropped
- drop_count  out  16  total dropped requests across all channels; saturates at 16'hFFFF

## Operation
- Each channel has a FIFO of FIFO_DEPTH headers. req_valid with the FIFO not full writes the header. req_valid with the FIFO full drops the request, sets overflow[i], and increments drop_count (saturating).
- Arbiter: each cycle it grants at most one non-empty FIFO.
  - Round-robin search starts at channel (last_grant+1) mod NUM_CHANNELS.
  - The granted FIFO is popped, and its header plus channel index and mode enter stage 1.
- Generate mode: bytes 10–11 (the checksum field) are forced to zero before summing.
- Stage 1: ten 16-bit big-endian words are summed as two 5-word partial sums, 19 bits each, registered.
- Stage 2: the partials are added (20 bits), then folded once: sum[15:0] + sum[19:16], registered as 17 bits.
- Stage 3: fold again to 16 bits: s[15:0] + s[16].
  - Generate: result = ~fold.
  - Verify: ok = (fold == 16'hFFFF).
- The stage-3 result is written into resp_data slice [ch] and resp_valid[ch] is pulsed. Other channels' resp_data hold their last values.
- Per-channel ordering is preserved; ordering across channels is not guaranteed.
- overflow is cleared by clear_overflow. If an overflow event and clear_overflow occur in the same cycle, set wins. drop_count is cleared only by reset.
- Pipeline valid bits advance unconditionally, with no stalls.

## Timing
- Reset (aresetn low, asynchronous) drives:
  - resp_valid = 0, resp_data = 0, overflow = 0, drop_count = 0
  - all FIFOs empty, all pipeline valid bits 0, last_grant = NUM_CHANNELS-1 (so channel 0 wins first)
- Reset asserted mid-operation discards all queued and in-flight requests, with no partial responses. The first request is accepted on the first clock edge after deassertion.
- Latency: req_valid in cycle 0 leads to resp_valid in cycle 4 when the channel FIFO is empty and no other channel is granted.
  - Cycle 0: FIFO write.
  - Cycle 1: grant and pop, stage 1 load.
  - Cycles 2 and 3: stages 2 and 3.
  - Cycle 4: registered output.
- With contention, latency is 4 + (cycles waiting for grant). Worst case for a head-of-queue entry: NUM_CHANNELS-1 extra cycles.
- Throughput: one header per cycle in aggregate. Sustained per-channel rate ≤ 1/NUM_CHANNELS is lossless when all channels are active.
- A FIFO write and pop in the same cycle on a full FIFO: the pop happens first, so the write is accepted and no overflow occurs. This applies only when the granted entry pops in that cycle.
- The write on an empty FIFO is not granted in the same cycle; there is no bypass.
- Each resp_valid[i] is at most one per cycle and always exactly one cycle wide.

## Test plan
- Generate, channel 1: header 4500 0073 0000 4000 4011 0000 c0a8 0001 c0a8 00c7 → resp_data[1] = 16'hB861 with resp_valid[1] exactly 4 cycles after req_valid.
- Verify, channel 0: same header with checksum B861 → resp_data[0] = 16'h0001. Same header with checksum B862 → 16'h0000.
- Simultaneous req_valid on both channels every cycle for 8 cycles, FIFO_DEPTH 4 → responses alternate starting with ch0. Drops begin once a FIFO fills; overflow and drop_count match a reference model exactly. All non-dropped responses are correct and in order.
- Overflow clear: one channel at 100% rate to force a drop, then clear_overflow in the same cycle as a new drop → overflow stays 1. Clear with no drop → 0. drop_count unchanged by the clear.
- Saturation: force 65540 drops → drop_count holds 16'hFFFF.
- Reset mid-flight: assert aresetn low with 3 requests queued and 2 in the pipeline → no resp_valid after reset. A fresh request afterwards → response in 4 cycles; channel 0 is granted first.
